dlatch_monitor: RTL and testbench
=================================

# dlatch_monitor

Synthesizable, clocked checker that observes the `d`, `en` and `q` pins of a level-sensitive D latch and verifies that `q` follows transparent/hold behaviour. It is the observing end of the latch interface: the stimulus side drives `d` and `en`, and this block judges the response. It sits beside the latch under test in on-board or emulated self-check builds. It reports a sticky error, saturating check and error counts, and, optionally, a snapshot of the first failure.

## Interface
- `SETTLE_CYC`, default 2: clock cycles `q_obs` is given to settle after a relevant input change before it is compared (legal range 1..15).
- `CNT_W`, default 8: width of the check and error counters.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle pulse that clears counters and arms monitoring.
- `stop` in 1: one-cycle pulse that returns to idle; results are held.
- `d_obs`, `en_obs`, `q_obs` in 1 each: observed latch pins, synchronous to `clk`.
- `active` out 1: high while monitoring (not IDLE).
- `err_sticky` out 1: set on any mismatch; cleared only by reset or `start`.
- `chk_cnt` out CNT_W: number of compares performed, saturating.
- `err_cnt` out CNT_W: number of mismatches, saturating.
- `first_err_stamp` out 16: cycle stamp of the first mismatch. Present only with the macro.
- `first_err_snap` out 3: {d, en, expected q} at the first mismatch. Present only with the macro.

## Operation
- The reference model holds `exp_q` and `exp_valid`.
  - Each cycle in which the sampled `en_obs`=1: `exp_q` <= `d_obs` and `exp_valid` <= 1.
  - When `en_obs`=0, `exp_q` holds.
  - `start` clears `exp_valid`, so the latch's unknown power-up value is never checked.
- A relevant change is either of:
  - `en_obs` differs from its previous sample;
  - `en_obs`=1 and `d_obs` differs from its previous sample.
  - A change of `d_obs` while `en_obs`=0 is not relevant.
- FSM states are IDLE, SETTLE and CHECK.
  - IDLE -> SETTLE on `start`; the settle counter loads SETTLE_CYC.
  - In SETTLE, the counter decrements each cycle and the FSM moves to CHECK when the counter reaches 0.
  - A relevant change in SETTLE or CHECK reloads the counter and enters (or stays in) SETTLE.
  - In CHECK with `exp_valid`=1, each cycle does the following:
    - `chk_cnt`++;
    - if `q_obs`!=`exp_q`, then `err_cnt`++ and `err_sticky`<=1.
  - CHECK with `exp_valid`=0: no compare and no count.
  - `stop` sends any state to IDLE. Counters, the sticky flag and the snapshot hold their values.
  - `start` in SETTLE or CHECK restarts: counters clear and the FSM enters SETTLE.
  - If `start` and `stop` are asserted in the same cycle, `start` wins.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset values:
  - `active`=0 and `err_sticky`=0;
  - `chk_cnt`=`err_cnt`=0;
  - FSM=IDLE, `exp_valid`=0;
  - `first_err_stamp`=0 and `first_err_snap`=0.
- Reset asserted mid-check aborts immediately, and all of the above values apply asynchronously.
- `active` rises the cycle after `start` is sampled and falls the cycle after `stop` is sampled.
- The first compare occurs SETTLE_CYC+1 cycles after the last relevant change is sampled.
- Results are registered: `chk_cnt`, `err_cnt` and `err_sticky` update one cycle after the compared sample.
- A relevant change on the same cycle as a would-be compare suppresses that compare.

## Configuration
- `DLATCH_MONITOR_CAPTURE_EN` defined:
  - a 16-bit free-running stamp counter clears on `start` and wraps silently;
  - the first mismatch after `start` latches the stamp into `first_err_stamp` and {d_obs, en_obs, exp_q} into `first_err_snap`;
  - later mismatches do not overwrite the snapshot.
- Macro undefined: the stamp counter, snapshot registers and both snapshot ports are absent.

## Structure
- Package `dlatch_monitor_pkg` contains:
  - the FSM state enum (IDLE, SETTLE, CHECK);
  - the stamp width constant (16);
  - the snapshot width constant (3).
- Sub-module `dlatch_ref_model` contains the previous-sample registers, relevant-change detect, `exp_q` and `exp_valid`.
- The top level contains the FSM, settle counter, counters and capture logic.

## Test plan
All scenarios use SETTLE_CYC=2.
- Reset: drop `rst_n` mid-CHECK with `err_cnt`=3 -> all outputs 0 in the same cycle; after release FSM=IDLE and `active`=0.
- Correct latch: `start`, then `en`=1 `d`=1 for 6 cycles with `q_obs`=1 -> `chk_cnt`=3, `err_cnt`=0, `err_sticky`=0.
- Hold check: `en` 1->0 with `d`=1, then toggle `d` every cycle with `q_obs`=1 -> the `d` toggles cause no reloads, compares continue and `err_cnt`=0. Then force `q_obs`=0 for 2 cycles -> `err_cnt`=2 and `err_sticky`=1.
- Saturation: CNT_W=4, 20 mismatching CHECK cycles -> `err_cnt`=15 and `chk_cnt`=15.
- Start/stop: `start`+`stop` in the same cycle from CHECK -> counters clear and FSM=SETTLE. `stop` alone -> `active`=0 and counts held.
- Capture (macro on): first mismatch at stamp 7 with d=0, en=1, exp=0 -> `first_err_stamp`=7 and `first_err_snap`=3'b010; a second mismatch leaves both unchanged.

Source files
------------

// File: rtl/dlatch_monitor_pkg.sv
// -----------------------------------------------------------------------------
// dlatch_monitor_pkg
// Shared types and constants for the D-latch monitor slice.
//   mon_state_e : monitor FSM states (IDLE, SETTLE, CHECK)
//   STAMP_W     : width of the free-running cycle stamp
//   SNAP_W      : width of the first-failure snapshot {d, en, expected q}
//   SETTLE_W    : width of the settle down-counter (holds 1..15)
// -----------------------------------------------------------------------------
package dlatch_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2
   } mon_state_e;

   localparam int STAMP_W  = 16;
   localparam int SNAP_W   = 3;
   localparam int SETTLE_W = 4;

endpackage

// File: rtl/dlatch_ref_model.sv
// -----------------------------------------------------------------------------
// dlatch_ref_model
// Reference model of a level-sensitive D latch as seen from the clock domain.
// Tracks the expected q, whether that expectation is trustworthy, and flags
// input changes that the latch output must be given time to follow.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   start             : clears exp_valid (power-up q is unknown)
//   d_obs, en_obs     : sampled latch inputs
//   exp_q, exp_valid  : registered expected q and its validity
//   rel_change        : combinational; en toggled, or d moved while transparent
// -----------------------------------------------------------------------------
module dlatch_ref_model (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic d_obs,
   input  logic en_obs,
   output logic exp_q,
   output logic exp_valid,
   output logic rel_change
);

   logic d_prev_r;
   logic en_prev_r;
   logic exp_q_r;
   logic exp_valid_r;
   logic rel_change_s;

   // Previous-sample registers and the expected-q / validity state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_prev_r    <= 1'b0;
         en_prev_r   <= 1'b0;
         exp_q_r     <= 1'b0;
         exp_valid_r <= 1'b0;
      end else begin
         d_prev_r  <= d_obs;
         en_prev_r <= en_obs;
         // Transparent: q follows d; opaque: q holds.
         if (en_obs) begin
            exp_q_r <= d_obs;
         end else begin
            exp_q_r <= exp_q_r;
         end
         // A start discards any history; only a later transparent sample
         // makes the expectation trustworthy again.
         if (start) begin
            exp_valid_r <= 1'b0;
         end else if (en_obs) begin
            exp_valid_r <= 1'b1;
         end else begin
            exp_valid_r <= exp_valid_r;
         end
      end
   end

   // Relevant-change detect: d only matters while the latch is transparent.
   always_comb begin
      rel_change_s = 1'b0;
      if (en_obs != en_prev_r) begin
         rel_change_s = 1'b1;
      end else if (en_obs && (d_obs != d_prev_r)) begin
         rel_change_s = 1'b1;
      end else begin
         rel_change_s = 1'b0;
      end
   end

   assign exp_q      = exp_q_r;
   assign exp_valid  = exp_valid_r;
   assign rel_change = rel_change_s;

endmodule

// File: rtl/dlatch_monitor.sv
// -----------------------------------------------------------------------------
// dlatch_monitor
// Clocked checker for a level-sensitive D latch. After every relevant input
// change q_obs is given SETTLE_CYC cycles to settle, then compared against the
// reference model each cycle until the next relevant change.
// Parameters:
//   SETTLE_CYC (1..15) : settle cycles before compares resume
//   CNT_W              : width of the saturating check / error counters
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   start, stop              : one-cycle control pulses (start wins)
//   d_obs, en_obs, q_obs     : observed latch pins
//   active                   : monitor not idle
//   err_sticky               : any mismatch since reset/start
//   chk_cnt, err_cnt         : saturating compare / mismatch counts
//   first_err_stamp/_snap    : first-failure capture, only with
//                              DLATCH_MONITOR_CAPTURE_EN defined
// -----------------------------------------------------------------------------
module dlatch_monitor
   import dlatch_monitor_pkg::*;
#(
   parameter int SETTLE_CYC = 2,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             d_obs,
   input  logic             en_obs,
   input  logic             q_obs,
   output logic             active,
   output logic             err_sticky,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] err_cnt
`ifdef DLATCH_MONITOR_CAPTURE_EN
  ,output logic [STAMP_W-1:0] first_err_stamp,
   output logic [SNAP_W-1:0]  first_err_snap
`endif
);

   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC);

   mon_state_e          state_r;
   mon_state_e          state_s;
   logic [SETTLE_W-1:0] cnt_r;
   logic [SETTLE_W-1:0] cnt_s;
   logic                active_r;
   logic                err_sticky_r;
   logic [CNT_W-1:0]    chk_cnt_r;
   logic [CNT_W-1:0]    err_cnt_r;
   logic                exp_q_s;
   logic                exp_valid_s;
   logic                rel_change_s;
   logic                cmp_s;
   logic                mismatch_s;

   // Saturating increment: all-ones is sticky.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   dlatch_ref_model u_ref (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .d_obs      (d_obs),
      .en_obs     (en_obs),
      .exp_q      (exp_q_s),
      .exp_valid  (exp_valid_s),
      .rel_change (rel_change_s)
   );

   // Next-state and settle-counter logic; start beats stop beats everything.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      if (start) begin
         state_s = SETTLE;
         cnt_s   = SETTLE_LOAD;
      end else if (stop) begin
         state_s = IDLE;
         cnt_s   = {SETTLE_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               state_s = IDLE;
               cnt_s   = cnt_r;
            end
            SETTLE: begin
               if (rel_change_s) begin
                  state_s = SETTLE;
                  cnt_s   = SETTLE_LOAD;
               end else if (cnt_r <= {{(SETTLE_W-1){1'b0}}, 1'b1}) begin
                  // Counter reaches zero on this edge: next cycle compares.
                  state_s = CHECK;
                  cnt_s   = {SETTLE_W{1'b0}};
               end else begin
                  state_s = SETTLE;
                  cnt_s   = cnt_r - {{(SETTLE_W-1){1'b0}}, 1'b1};
               end
            end
            CHECK: begin
               if (rel_change_s) begin
                  state_s = SETTLE;
                  cnt_s   = SETTLE_LOAD;
               end else begin
                  state_s = CHECK;
                  cnt_s   = cnt_r;
               end
            end
            default: begin
               state_s = IDLE;
               cnt_s   = {SETTLE_W{1'b0}};
            end
         endcase
      end
   end

   // Compare qualifier: a relevant change or a control pulse on this cycle
   // suppresses the compare.
   always_comb begin
      cmp_s      = 1'b0;
      mismatch_s = 1'b0;
      if ((state_r == CHECK) && exp_valid_s && !rel_change_s && !start && !stop) begin
         cmp_s      = 1'b1;
         mismatch_s = (q_obs != exp_q_s);
      end else begin
         cmp_s      = 1'b0;
         mismatch_s = 1'b0;
      end
   end

   // FSM state, settle counter and active flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= {SETTLE_W{1'b0}};
         active_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         active_r <= (state_s != IDLE);
      end
   end

   // Result counters and sticky error; held across stop, cleared by start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_cnt_r    <= {CNT_W{1'b0}};
         err_cnt_r    <= {CNT_W{1'b0}};
         err_sticky_r <= 1'b0;
      end else if (start) begin
         chk_cnt_r    <= {CNT_W{1'b0}};
         err_cnt_r    <= {CNT_W{1'b0}};
         err_sticky_r <= 1'b0;
      end else if (cmp_s) begin
         chk_cnt_r <= sat_inc(chk_cnt_r);
         if (mismatch_s) begin
            err_cnt_r    <= sat_inc(err_cnt_r);
            err_sticky_r <= 1'b1;
         end else begin
            err_cnt_r    <= err_cnt_r;
            err_sticky_r <= err_sticky_r;
         end
      end else begin
         chk_cnt_r    <= chk_cnt_r;
         err_cnt_r    <= err_cnt_r;
         err_sticky_r <= err_sticky_r;
      end
   end

   assign active     = active_r;
   assign err_sticky = err_sticky_r;
   assign chk_cnt    = chk_cnt_r;
   assign err_cnt    = err_cnt_r;

`ifdef DLATCH_MONITOR_CAPTURE_EN
   logic [STAMP_W-1:0] stamp_r;
   logic [STAMP_W-1:0] first_err_stamp_r;
   logic [SNAP_W-1:0]  first_err_snap_r;
   logic               captured_r;

   // Free-running stamp and one-shot first-failure capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stamp_r           <= {STAMP_W{1'b0}};
         first_err_stamp_r <= {STAMP_W{1'b0}};
         first_err_snap_r  <= {SNAP_W{1'b0}};
         captured_r        <= 1'b0;
      end else if (start) begin
         stamp_r           <= {STAMP_W{1'b0}};
         first_err_stamp_r <= {STAMP_W{1'b0}};
         first_err_snap_r  <= {SNAP_W{1'b0}};
         captured_r        <= 1'b0;
      end else begin
         stamp_r <= stamp_r + {{(STAMP_W-1){1'b0}}, 1'b1};
         if (mismatch_s && !captured_r) begin
            first_err_stamp_r <= stamp_r;
            first_err_snap_r  <= {d_obs, en_obs, exp_q_s};
            captured_r        <= 1'b1;
         end else begin
            first_err_stamp_r <= first_err_stamp_r;
            first_err_snap_r  <= first_err_snap_r;
            captured_r        <= captured_r;
         end
      end
   end

   assign first_err_stamp = first_err_stamp_r;
   assign first_err_snap  = first_err_snap_r;
`endif

endmodule

// File: tb/tb_dlatch_monitor.sv
// -----------------------------------------------------------------------------
// tb_dlatch_monitor
// Directed bench for dlatch_monitor (SETTLE_CYC=2). A CNT_W=8 instance and a
// CNT_W=4 instance observe the same pins; the narrow one exercises saturation.
// Inputs change #1 after a rising edge and outputs are read at the same point.
// -----------------------------------------------------------------------------
module tb_dlatch_monitor;
   import dlatch_monitor_pkg::*;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       start  = 1'b0;
   logic       stop   = 1'b0;
   logic       d_obs  = 1'b0;
   logic       en_obs = 1'b0;
   logic       q_obs  = 1'b0;
   logic       active, err_sticky;
   logic [7:0] chk_cnt, err_cnt;
   logic       active4, err_sticky4;
   logic [3:0] chk_cnt4, err_cnt4;
`ifdef DLATCH_MONITOR_CAPTURE_EN
   logic [15:0] first_err_stamp, first_err_stamp4;
   logic [2:0]  first_err_snap, first_err_snap4;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   dlatch_monitor #(.SETTLE_CYC(2), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .d_obs(d_obs), .en_obs(en_obs), .q_obs(q_obs),
      .active(active), .err_sticky(err_sticky),
      .chk_cnt(chk_cnt), .err_cnt(err_cnt)
`ifdef DLATCH_MONITOR_CAPTURE_EN
     ,.first_err_stamp(first_err_stamp), .first_err_snap(first_err_snap)
`endif
   );

   dlatch_monitor #(.SETTLE_CYC(2), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .d_obs(d_obs), .en_obs(en_obs), .q_obs(q_obs),
      .active(active4), .err_sticky(err_sticky4),
      .chk_cnt(chk_cnt4), .err_cnt(err_cnt4)
`ifdef DLATCH_MONITOR_CAPTURE_EN
     ,.first_err_stamp(first_err_stamp4), .first_err_snap(first_err_snap4)
`endif
   );

   // Apply one cycle of inputs, then settle #1 past the rising edge.
   task automatic drive(input logic st, input logic sp, input logic dv,
                        input logic ev, input logic qv);
      start  = st;
      stop   = sp;
      d_obs  = dv;
      en_obs = ev;
      q_obs  = qv;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      tests_run++; if (active !== 1'b0) begin tests_failed++; $display("FAIL reset_active: got %b want 0", active); end
      tests_run++; if (err_sticky !== 1'b0) begin tests_failed++; $display("FAIL reset_sticky: got %b want 0", err_sticky); end
      tests_run++; if (chk_cnt !== 8'd0 || err_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_counts: got chk=%0d err=%0d want 0/0", chk_cnt, err_cnt); end
      #21 rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++; if (dut.state_r !== IDLE || active !== 1'b0) begin tests_failed++; $display("FAIL reset_idle: got state=%0d active=%b want IDLE/0", dut.state_r, active); end
   endtask

   task automatic test_correct_latch();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tests_run++; if (active !== 1'b1) begin tests_failed++; $display("FAIL start_active: got %b want 1", active); end
      for (int i = 1; i <= 6; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
         if (i == 3) begin
            tests_run++; if (chk_cnt !== 8'd0) begin tests_failed++; $display("FAIL settle_no_compare: got chk=%0d want 0", chk_cnt); end
         end
         if (i == 4) begin
            tests_run++; if (chk_cnt !== 8'd1) begin tests_failed++; $display("FAIL first_compare: got chk=%0d want 1", chk_cnt); end
         end
      end
      tests_run++; if (chk_cnt !== 8'd3 || err_cnt !== 8'd0 || err_sticky !== 1'b0) begin tests_failed++; $display("FAIL correct_latch: got chk=%0d err=%0d sticky=%b want 3/0/0", chk_cnt, err_cnt, err_sticky); end
   endtask

   task automatic test_hold();
      // en falls: relevant change suppresses this cycle's compare.
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tests_run++; if (chk_cnt !== 8'd3 || dut.state_r !== SETTLE) begin tests_failed++; $display("FAIL hold_suppress: got chk=%0d state=%0d want 3/SETTLE", chk_cnt, dut.state_r); end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, (i % 2) == 1, 1'b0, 1'b1);
      end
      tests_run++; if (chk_cnt !== 8'd6 || err_cnt !== 8'd0) begin tests_failed++; $display("FAIL hold_d_toggle: got chk=%0d err=%0d want 6/0", chk_cnt, err_cnt); end
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++; if (err_cnt !== 8'd2 || err_sticky !== 1'b1 || chk_cnt !== 8'd8) begin tests_failed++; $display("FAIL hold_mismatch: got chk=%0d err=%0d sticky=%b want 8/2/1", chk_cnt, err_cnt, err_sticky); end
   endtask

   task automatic test_start_stop();
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tests_run++; if (chk_cnt !== 8'd2 || err_cnt !== 8'd1) begin tests_failed++; $display("FAIL restart_pre: got chk=%0d err=%0d want 2/1", chk_cnt, err_cnt); end
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tests_run++; if (chk_cnt !== 8'd0 || err_cnt !== 8'd0 || err_sticky !== 1'b0) begin tests_failed++; $display("FAIL start_stop_clear: got chk=%0d err=%0d sticky=%b want 0/0/0", chk_cnt, err_cnt, err_sticky); end
      tests_run++; if (dut.state_r !== SETTLE || active !== 1'b1) begin tests_failed++; $display("FAIL start_wins: got state=%0d active=%b want SETTLE/1", dut.state_r, active); end
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tests_run++; if (active !== 1'b0 || dut.state_r !== IDLE) begin tests_failed++; $display("FAIL stop_idle: got active=%b state=%0d want 0/IDLE", active, dut.state_r); end
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tests_run++; if (chk_cnt !== 8'd1 || err_cnt !== 8'd1 || err_sticky !== 1'b1) begin tests_failed++; $display("FAIL stop_hold: got chk=%0d err=%0d sticky=%b want 1/1/1", chk_cnt, err_cnt, err_sticky); end
   endtask

   task automatic test_saturation();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (23) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tests_run++; if (err_cnt4 !== 4'd15 || chk_cnt4 !== 4'd15) begin tests_failed++; $display("FAIL saturate_w4: got chk=%0d err=%0d want 15/15", chk_cnt4, err_cnt4); end
      tests_run++; if (err_cnt !== 8'd20 || chk_cnt !== 8'd20) begin tests_failed++; $display("FAIL count_w8: got chk=%0d err=%0d want 20/20", chk_cnt, err_cnt); end
   endtask

`ifdef DLATCH_MONITOR_CAPTURE_EN
   task automatic test_capture();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++; if (first_err_stamp !== 16'd0 || first_err_snap !== 3'b000) begin tests_failed++; $display("FAIL capture_clear: got stamp=%0d snap=%b want 0/000", first_err_stamp, first_err_snap); end
      repeat (7) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tests_run++; if (first_err_stamp !== 16'd7 || first_err_snap !== 3'b010 || err_cnt !== 8'd1) begin tests_failed++; $display("FAIL capture_first: got stamp=%0d snap=%b err=%0d want 7/010/1", first_err_stamp, first_err_snap, err_cnt); end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tests_run++; if (first_err_stamp !== 16'd7 || first_err_snap !== 3'b010 || err_cnt !== 8'd2) begin tests_failed++; $display("FAIL capture_hold: got stamp=%0d snap=%b err=%0d want 7/010/2", first_err_stamp, first_err_snap, err_cnt); end
   endtask
`endif

   task automatic test_reset_mid_check();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (6) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tests_run++; if (err_cnt !== 8'd3 || dut.state_r !== CHECK) begin tests_failed++; $display("FAIL pre_reset: got err=%0d state=%0d want 3/CHECK", err_cnt, dut.state_r); end
      #2 rst_n = 1'b0;
      #1;
      tests_run++; if (active !== 1'b0 || err_sticky !== 1'b0 || chk_cnt !== 8'd0 || err_cnt !== 8'd0) begin tests_failed++; $display("FAIL async_reset: got active=%b sticky=%b chk=%0d err=%0d want all 0", active, err_sticky, chk_cnt, err_cnt); end
`ifdef DLATCH_MONITOR_CAPTURE_EN
      tests_run++; if (first_err_stamp !== 16'd0 || first_err_snap !== 3'b000) begin tests_failed++; $display("FAIL async_reset_capture: got stamp=%0d snap=%b want 0/000", first_err_stamp, first_err_snap); end
`endif
      #3 rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tests_run++; if (dut.state_r !== IDLE || active !== 1'b0 || chk_cnt !== 8'd0) begin tests_failed++; $display("FAIL post_reset_idle: got state=%0d active=%b chk=%0d want IDLE/0/0", dut.state_r, active, chk_cnt); end
   endtask

   initial begin
      test_reset();
      test_correct_latch();
      test_hold();
      test_start_stop();
      test_saturation();
`ifdef DLATCH_MONITOR_CAPTURE_EN
      test_capture();
`endif
      test_reset_mid_check();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
